// File: rtl/bexkat1Def.sv
// ============================================================================
// bexkat1Def : shared bexkat1 pipeline constants, writeback state, load extension
// Revision   : 1.0
// ============================================================================
`default_nettype none

package bexkat1Def;

    // Instruction type field ir[31:28], shared with decode
    localparam logic [3:0] T_INH    = 4'h0;
    localparam logic [3:0] T_PUSH   = 4'h1;
    localparam logic [3:0] T_POP    = 4'h2;
    localparam logic [3:0] T_CMP    = 4'h3;
    localparam logic [3:0] T_MOV    = 4'h4;
    localparam logic [3:0] T_FP     = 4'h5;
    localparam logic [3:0] T_ALU    = 4'h6;
    localparam logic [3:0] T_INT    = 4'h7;
    localparam logic [3:0] T_LDI    = 4'h8;
    localparam logic [3:0] T_LOAD   = 4'h9;
    localparam logic [3:0] T_STORE  = 4'ha;
    localparam logic [3:0] T_BRANCH = 4'hb;
    localparam logic [3:0] T_JUMP   = 4'hc;
    localparam logic [3:0] T_INTU   = 4'hd;

    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_BYTE = 2'd1;
    localparam logic [1:0] W_HALF = 2'd2;
    localparam logic [1:0] W_WORD = 2'd3;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

    function automatic logic [31:0] ext_load(input logic [31:0] d, input logic [1:0] w);
        logic [31:0] r;
        case (w)
            W_BYTE:  r = {24'h0, d[7:0]};
            W_HALF:  r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iwriteback.sv
// ============================================================================
// iwriteback : bexkat1 writeback stage, one register write per instruction,
//              load wait with bus-error timeout. Option: BEXKAT1_WB_BYPASS_EN
// Revision   : 1.0
// ============================================================================
`default_nettype none

module iwriteback
    import bexkat1Def::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] ir_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] result_i,
    input  logic [1:0]  reg_write_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    input  logic        stall_i,
    output logic [1:0]  reg_write_o,
    output logic [3:0]  reg_write_addr_o,
    output logic [31:0] reg_data_o,
    output logic        stall_o,
    output logic        exc_o,
`ifdef BEXKAT1_WB_BYPASS_EN
    output logic        fwd_valid_o,
    output logic [3:0]  fwd_addr_o,
    output logic [31:0] fwd_data_o,
`endif
    output logic [31:0] exc_pc_o
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    wb_state_t   state;
    logic [7:0]  counter;
    logic [3:0]  lat_addr;
    logic [1:0]  lat_width;
    logic [31:0] lat_pc;

    logic is_load;
    logic unused_ir;

    assign is_load   = (ir_i[31:28] == T_LOAD) && (reg_write_i != W_NONE);
    assign unused_ir = ^{ir_i[63:32], ir_i[27:24], ir_i[19:0]};

    // A stalled load has not been accepted yet, so it does not hold the pipe
    assign stall_o = (state == WB_WAIT) ||
                     (!stall_i && is_load && !mem_ack_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state            <= WB_IDLE;
            counter          <= 8'd0;
            lat_addr         <= 4'd0;
            lat_width        <= W_NONE;
            lat_pc           <= 32'd0;
            reg_write_o      <= W_NONE;
            reg_write_addr_o <= 4'd0;
            reg_data_o       <= 32'd0;
            exc_o            <= 1'b0;
            exc_pc_o         <= 32'd0;
        end else begin
            reg_write_o <= W_NONE;
            exc_o       <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (!stall_i) begin
                        if (is_load && !mem_ack_i) begin
                            lat_addr  <= ir_i[23:20];
                            lat_width <= reg_write_i;
                            lat_pc    <= pc_i;
                            counter   <= 8'd1;
                            state     <= WB_WAIT;
                        end else begin
                            reg_write_o      <= reg_write_i;
                            reg_write_addr_o <= ir_i[23:20];
                            reg_data_o       <= is_load ? ext_load(mem_data_i, reg_write_i)
                                                        : result_i;
                        end
                    end
                end
                WB_WAIT: begin
                    // An ack arriving on the timeout cycle still completes the load
                    if (mem_ack_i) begin
                        reg_write_o      <= lat_width;
                        reg_write_addr_o <= lat_addr;
                        reg_data_o       <= ext_load(mem_data_i, lat_width);
                        counter          <= 8'd0;
                        state            <= WB_IDLE;
                    end else if (counter == TIMEOUT) begin
                        exc_o    <= 1'b1;
                        exc_pc_o <= lat_pc;
                        counter  <= 8'd0;
                        state    <= WB_IDLE;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

`ifdef BEXKAT1_WB_BYPASS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_valid_o <= 1'b0;
            fwd_addr_o  <= 4'd0;
            fwd_data_o  <= 32'd0;
        end else begin
            fwd_valid_o <= (reg_write_o == W_WORD);
            fwd_addr_o  <= reg_write_addr_o;
            fwd_data_o  <= reg_data_o;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iwriteback.sv
// ============================================================================
// tb_iwriteback : randomized scoreboard bench for iwriteback
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_iwriteback;
    import bexkat1Def::*;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] ir;
    logic [31:0] pc, result, mem_data;
    logic [1:0]  reg_write_in;
    logic        mem_ack, stall_in;
    logic [1:0]  reg_write_out;
    logic [3:0]  reg_write_addr;
    logic [31:0] reg_data, exc_pc;
    logic        stall_out, exc;
`ifdef BEXKAT1_WB_BYPASS_EN
    logic        fwd_valid;
    logic [3:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    always #5 clk = ~clk;

    iwriteback #(.MEM_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst_n), .ir_i(ir), .pc_i(pc), .result_i(result),
        .reg_write_i(reg_write_in), .mem_data_i(mem_data), .mem_ack_i(mem_ack),
        .stall_i(stall_in), .reg_write_o(reg_write_out),
        .reg_write_addr_o(reg_write_addr), .reg_data_o(reg_data),
        .stall_o(stall_out), .exc_o(exc),
`ifdef BEXKAT1_WB_BYPASS_EN
        .fwd_valid_o(fwd_valid), .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data),
`endif
        .exc_pc_o(exc_pc)
    );

    typedef struct {
        bit          is_exc;
        logic [1:0]  w;
        logic [3:0]  a;
        logic [31:0] d;
        int          at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [31:0] model_ext(input logic [31:0] d, input logic [1:0] w);
        if (w == 2'd1) return d & 32'h0000_00ff;
        if (w == 2'd2) return d & 32'h0000_ffff;
        return d;
    endfunction

    // Monitor: pops one expectation per observed write or exception
    logic [1:0]  fwd_w_exp = 2'd0;
    logic [3:0]  fwd_a_exp = 4'd0;
    logic [31:0] fwd_d_exp = 32'd0;

    initial begin
        exp_t e;
        logic [1:0]  cur_w;
        logic [3:0]  cur_a;
        logic [31:0] cur_d;
        forever begin
            @(posedge clk);
            #1;
            cur_w = 2'd0; cur_a = 4'd0; cur_d = 32'd0;
            if (rst_n) begin
`ifdef BEXKAT1_WB_BYPASS_EN
                chk("fwd_valid", 32'(fwd_valid), 32'(fwd_w_exp == 2'd3));
                if (fwd_w_exp == 2'd3) begin
                    chk("fwd_addr", 32'(fwd_addr), 32'(fwd_a_exp));
                    chk("fwd_data", fwd_data, fwd_d_exp);
                end
`endif
                if (reg_write_out != 2'd0 || exc) begin
                    if (q.size() == 0) begin
                        chk("spurious_output", {29'd0, reg_write_out, exc}, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("output_cycle", 32'(cyc), 32'(e.at));
                        if (e.is_exc) begin
                            chk("exc", 32'(exc), 32'd1);
                            chk("exc_pc", exc_pc, e.d);
                            chk("no_write_on_exc", 32'(reg_write_out), 32'd0);
                        end else begin
                            chk("write_width", 32'(reg_write_out), 32'(e.w));
                            chk("write_addr", 32'(reg_write_addr), 32'(e.a));
                            chk("write_data", reg_data, e.d);
                            chk("exc_on_write", 32'(exc), 32'd0);
                            cur_w = e.w; cur_a = e.a; cur_d = e.d;
                        end
                    end
                end
            end
            fwd_w_exp = cur_w; fwd_a_exp = cur_a; fwd_d_exp = cur_d;
        end
    end

    task automatic idle_cycle();
        @(negedge clk);
        ir = {$urandom, $urandom}; reg_write_in = 2'd0; stall_in = 1'b0;
        mem_ack = 1'($urandom); mem_data = $urandom; result = $urandom; pc = $urandom;
    endtask

    // Issue one instruction: optional stalled cycles, then presentation, then load wait
    task automatic issue(input logic [3:0] typ, input logic [3:0] ra, input logic [1:0] w,
                         input logic [31:0] res, input logic [31:0] md, input logic [31:0] ipc,
                         input int stalls, input int delay);
        bit ld;
        ld = (typ == T_LOAD) && (w != 2'd0);
        for (int s = 0; s < stalls; s++) begin
            @(negedge clk);
            ir = {$urandom, typ, 4'($urandom), ra, 20'($urandom)};
            reg_write_in = w; result = res; pc = ipc; stall_in = 1'b1;
            mem_ack = 1'($urandom); mem_data = $urandom;
        end
        @(negedge clk);
        ir = {$urandom, typ, 4'($urandom), ra, 20'($urandom)};
        reg_write_in = w; result = res; pc = ipc; stall_in = 1'b0;
        if (ld) begin
            mem_ack  = (delay == 0);
            mem_data = (delay == 0) ? md : $urandom;
        end else begin
            mem_ack  = 1'($urandom);
            mem_data = $urandom;
        end
        #1 chk("stall_o_present", 32'(stall_out), 32'(ld && delay != 0));
        if (!ld) begin
            if (w != 2'd0) q.push_back('{0, w, ra, res, cyc + 1});
        end else if (delay == 0) begin
            q.push_back('{0, w, ra, model_ext(md, w), cyc + 1});
        end else begin
            for (int j = 1; j <= T; j++) begin
                @(negedge clk);
                ir = {$urandom, $urandom}; reg_write_in = 2'($urandom);
                result = $urandom; pc = $urandom; stall_in = 1'($urandom);
                if (j == delay) begin
                    mem_ack = 1'b1; mem_data = md;
                    q.push_back('{0, w, ra, model_ext(md, w), cyc + 1});
                end else begin
                    mem_ack = 1'b0; mem_data = $urandom;
                    if (j == T) q.push_back('{1, 2'd0, 4'd0, ipc, cyc + 1});
                end
                #1 chk("stall_o_wait", 32'(stall_out), 32'd1);
                if (j == delay) break;
            end
        end
    endtask

    initial begin
        logic [3:0] typ;
        rst_n = 1'b0;
        ir = 64'd0; pc = 32'd0; result = 32'd0; reg_write_in = 2'd0;
        mem_data = 32'd0; mem_ack = 1'b0; stall_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_write", 32'(reg_write_out), 32'd0);
        chk("reset_addr", 32'(reg_write_addr), 32'd0);
        chk("reset_data", reg_data, 32'd0);
        chk("reset_exc", 32'(exc), 32'd0);
        chk("reset_exc_pc", exc_pc, 32'd0);
        chk("reset_stall", 32'(stall_out), 32'd0);
        rst_n = 1'b1;

        issue(T_ALU, 4'd5, 2'd3, 32'hDEADBEEF, 32'h0, 32'h10, 0, 0);
        idle_cycle();
        issue(T_LOAD, 4'd2, 2'd1, 32'h0, 32'h123456A5, 32'h20, 0, 3);
        issue(T_LOAD, 4'd7, 2'd2, 32'h0, 32'hFFFF8001, 32'h24, 0, 0);
        issue(T_ALU, 4'd1, 2'd3, 32'h0BADF00D, 32'h0, 32'h28, 0, 0);
        issue(T_LOAD, 4'd9, 2'd3, 32'h0, 32'h0, 32'h100, 0, T + 1);
        idle_cycle();
        issue(T_LOAD, 4'd4, 2'd3, 32'h0, 32'hCAFEF00D, 32'h30, 0, T);
        issue(T_ALU, 4'd6, 2'd3, 32'h55AA55AA, 32'h0, 32'h34, 3, 0);
        idle_cycle();
        idle_cycle();
        chk("exc_pc_held", exc_pc, 32'h100);

        for (int i = 0; i < 200; i++) begin
            typ = ($urandom_range(0, 9) < 4) ? T_LOAD : 4'($urandom);
            issue(typ, 4'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0,
                  int'($urandom_range(0, T + 2)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        repeat (3) idle_cycle();

        // Reset while a load waits, then a late ack: nothing may come out
        @(negedge clk);
        ir = {32'h0, T_LOAD, 4'h0, 4'd3, 20'h0}; reg_write_in = 2'd3;
        pc = 32'h200; stall_in = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        ir = 64'd0; reg_write_in = 2'd0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_write", 32'(reg_write_out), 32'd0);
        chk("midwait_reset_exc_pc", exc_pc, 32'd0);
        chk("midwait_reset_stall", 32'(stall_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_data = 32'h12345678;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (T + 3) @(negedge clk);
        chk("late_ack_no_exc_pc", exc_pc, 32'd0);
        chk("pending_expectations", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iwriteback.md
# iwriteback

Writeback stage of the bexkat1 pipeline: the writer side of the register-file write port that `idecode` consumes. It takes the completed instruction from the memory stage, waits for load data where needed, and zero-extends load data to the access width. It then drives exactly one single-cycle register write per instruction: `reg_write_o`, `reg_write_addr_o` and `reg_data_o` connect to the decode stage's `reg_write_i`, `reg_write_addr` and `reg_data_in`. It holds the pipeline while a load is outstanding and raises a bus-error exception if the load never completes.

## Interface
- `MEM_TIMEOUT`, default 16: maximum cycles spent waiting for `mem_ack_i` before a bus error is flagged; legal range 2..255.
- `clk_i  in  1`: clock; all state changes on rising edge.
- `rst_i  in  1`: asynchronous, active-low reset.
- `ir_i  in  64`: instruction from the memory stage. Type is [31:28]; destination register `ra` is [23:20].
- `pc_i  in  32`: PC of `ir_i`.
- `result_i  in  32`: ALU/MOV/LDI result.
- `reg_write_i  in  2`: write width. 0 = none/bubble, 1 = byte, 2 = halfword, 3 = word.
- `mem_data_i  in  32`: load data, valid when `mem_ack_i` is high.
- `mem_ack_i  in  1`: load data valid strobe.
- `stall_i  in  1`: downstream/global stall.
- `reg_write_o  out  2`: register-file write enable/width; a single-cycle pulse per instruction.
- `reg_write_addr_o  out  4`: destination register.
- `reg_data_o  out  32`: write data.
- `stall_o  out  1`: combinational; high while a load is outstanding.
- `exc_o  out  1`: one-cycle bus-error pulse.
- `exc_pc_o  out  32`: PC of the faulting load; held until the next exception.

## Operation
- **States:** `WB_IDLE`, `WB_WAIT`.
- **Load definition:** `ir_i[31:28] == T_LOAD` and `reg_write_i != 0`.
- **IDLE, `stall_i` high:** capture nothing; `reg_write_o` <= 0. A held instruction must not write twice.
- **IDLE, not a load:** `reg_write_o` <= `reg_write_i`, `reg_write_addr_o` <= `ir_i[23:20]`, `reg_data_o` <= `result_i` (no extension).
- **IDLE, load with `mem_ack_i` high in the same cycle:** write as above, but `reg_data_o` <= ext(`mem_data_i`, width).
- **IDLE, load with `mem_ack_i` low:**
  - latch `ra`, width and `pc_i`; counter <= 1; go to `WAIT`; `reg_write_o` <= 0.
  - `stall_o` is high in this cycle.
- **WAIT:**
  - `stall_o` = 1; inputs other than `mem_data_i`/`mem_ack_i` are ignored.
  - `mem_ack_i` high: write the latched `ra`/width with ext(`mem_data_i`); go to `IDLE`. This is accepted even while `stall_i` is high.
  - Otherwise counter increments. If counter == `MEM_TIMEOUT` with no ack: `exc_o` <= 1, `exc_pc_o` <= latched PC, no write, go to `IDLE`.
  - Ack in the same cycle the timeout is reached: the ack wins and no exception is raised.
- **ext():**
  - width 3: pass through.
  - width 2: {16'h0, d[15:0]}.
  - width 1: {24'h0, d[7:0]}.
- **`mem_ack_i` in IDLE with no load presented:** ignored.
- **Reset (`rst_i` low), any time including mid-WAIT:** state `IDLE`, counter 0, `reg_write_o` 0, `reg_write_addr_o` 0, `reg_data_o` 0, `exc_o` 0, `exc_pc_o` 0. A pending load is abandoned with no write and no exception.

## Timing
- Non-load and same-cycle-ack load: the write is visible on the outputs exactly 1 cycle after the input cycle.
- Delayed load: the write is visible 1 cycle after the `mem_ack_i` cycle.
- `stall_o` is asserted from the cycle the load is presented through the ack cycle inclusive.
- Timeout: `exc_o` is high `MEM_TIMEOUT` cycles after the load entered `WAIT`, for 1 cycle.
- `reg_write_o` is never high in two consecutive cycles for the same instruction.

## Configuration
- **`BEXKAT1_WB_BYPASS_EN` defined:** adds outputs `fwd_valid_o` (1), `fwd_addr_o` (4) and `fwd_data_o` (32).
  - These carry a registered copy of the previous cycle's write, so decode can forward past the register-file read.
  - `fwd_valid_o` = registered (`reg_write_o == 3`); partial writes are never forwarded.
  - Reset value of all three is 0.
- **Undefined:** the ports do not exist and behaviour is otherwise identical.

## Structure
- `bexkat1Def` holds:
  - the `T_LOAD` and other type constants (shared with decode);
  - width encodings `W_NONE`/`W_BYTE`/`W_HALF`/`W_WORD`;
  - the `wb_state_t` enum;
  - an `ext_load` function.
- No sub-module: a single flat module (state register, counter, output registers).

## Test plan
- ALU op: type T_ALU, ra=5, result 32'hDEADBEEF, width 3 -> next cycle `reg_write_o`=3, addr 5, data DEADBEEF; the following cycle `reg_write_o`=0.
- Byte load, ack after 3 cycles with data 32'h123456A5, ra=2 -> `stall_o` high 4 cycles; write of 32'h000000A5 to r2 one cycle after the ack.
- Halfword load with same-cycle ack, data 32'hFFFF8001 -> data 32'h00008001, no `stall_o` after the presentation cycle.
- Load with no ack, `MEM_TIMEOUT`=4, pc 32'h100 -> `exc_o` pulses once, `exc_pc_o`=32'h100, no write.
- Same ALU instruction held 3 cycles under `stall_i`, then released -> exactly one write pulse.
- Reset asserted in `WAIT` and a late ack after release -> no write, no exception; with the bypass macro on, `fwd_valid_o`=0.
